forward_ctrl_unit: RTL and testbench
====================================

FORWARD_CTRL_UNIT -- requirements
Module: forward_ctrl_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width (2^REG_ADDR_W architectural registers, register 0 hardwired zero).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports id_valid / id_reg_write / id_is_load / id_use_rs2 / id_use_imm  input  1 each  ID-stage instruction qualifiers.
REQ-005 SHALL have ports id_rs1 / id_rs2 / id_rd  input  REG_ADDR_W each  ID-stage source and destination registers.
REQ-006 SHALL have port flush  input  1  squash the instruction entering EX (taken branch).
REQ-007 SHALL have port stall  output  1  load-use hazard; upstream holds PC and IF/ID.
REQ-008 SHALL have ports fwd_a / fwd_b  output  2 each  select codes for the EX operand muxes: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result, 11 immediate (fwd_b only).

Function
REQ-009 SHALL keep three tracking slots EX, MEM, WB, each holding valid, rs1, rs2, rd, reg_write, is_load, use_rs2, use_imm.
REQ-010 SHALL advance each cycle: WB<=MEM, MEM<=EX, EX<=ID fields with valid=id_valid.
REQ-011 SHALL load EX with valid=0 (bubble) when stall or flush is high; MEM and WB still advance.
REQ-012 SHALL drive stall=1 combinationally when id_valid, EX.valid, EX.is_load, EX.reg_write, EX.rd!=0, and (EX.rd==id_rs1 or (id_use_rs2 and EX.rd==id_rs2)).
REQ-013 SHALL force stall=0 when flush=1 in the same cycle; flush takes priority.
REQ-014 SHALL compute fwd_a from registered EX state only: 01 if MEM.valid, MEM.reg_write, !MEM.is_load, MEM.rd!=0, MEM.rd==EX.rs1; else 10 if WB.valid, WB.reg_write, WB.rd!=0, WB.rd==EX.rs1; else 00.
REQ-015 SHALL compute fwd_b identically against EX.rs2, except 11 when EX.use_imm (highest priority) and 00 when !EX.use_rs2.
REQ-016 SHALL give MEM priority over WB when both match (youngest producer wins).
REQ-017 SHALL never forward register 0; a match on rd==0 yields 00.
REQ-018 SHALL drive fwd_a=fwd_b=00 when EX.valid=0.
REQ-019 SHALL have zero combinational path from ID inputs to fwd_a/fwd_b; stall is the only input-dependent output.

Reset
REQ-020 SHALL clear all slot valid bits and fields to 0 on reset; stall=0, fwd_a=fwd_b=00 in the cycle after reset.
REQ-021 SHALL give reset priority over flush and stall; reset mid-hazard drops all in-flight tracking.

Configuration
REQ-022 SHALL, with FWD_PERF_EN defined, add outputs stall_cnt and fwd_cnt (32 bits each), incrementing on cycles with stall=1 and on cycles with fwd_a or fwd_b in {01,10} respectively, wrapping at 2^32-1 to 0, cleared by reset.
REQ-023 SHALL, without FWD_PERF_EN, omit both ports and counters with no other behavioural change.

Structure
REQ-024 SHALL place fwd select encodings (FWD_REG, FWD_EXMEM, FWD_MEMWB, FWD_IMM) and the tracking-slot struct in shared package fwd_pkg.
REQ-025 SHALL implement operand selection in one sub-module fwd_select, instantiated twice (operand A, operand B).

Verification
REQ-026 SHALL cover: ALU r3<-, next instr uses rs1=r3 -> fwd_a=01 when consumer is in EX.
REQ-027 SHALL cover: producer r5, one unrelated instr, consumer rs2=r5, use_rs2=1 -> fwd_b=10.
REQ-028 SHALL cover: load r7, next instr rs1=r7 -> stall=1 for exactly one cycle, EX bubble, then fwd_a=10.
REQ-029 SHALL cover: back-to-back writes to r4, then consumer rs1=r4 -> fwd_a=01 (MEM priority); writes to r0 -> fwd_a=00.
REQ-030 SHALL cover: load-use with flush=1 same cycle -> stall=0, EX bubble; reset asserted mid-stall -> stall=0, fwd=00 next cycle.
REQ-031 SHALL cover: use_imm=1 with rs2 match -> fwd_b=11; with FWD_PERF_EN, 3 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: forward-select encodings and pipeline tracking slot shared by forward_ctrl_unit and fwd_select
package fwd_pkg;
  localparam int MAX_REG_ADDR_W = 8;
  typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10, FWD_IMM = 2'b11} fwd_sel_t;
  typedef logic [MAX_REG_ADDR_W-1:0] reg_addr_t;
  typedef struct packed {
    logic valid;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic reg_write;
    logic is_load;
    logic use_rs2;
    logic use_imm;
  } slot_t;
  function automatic logic writes_reg(slot_t s);
    return s.valid && s.reg_write && s.rd != '0;
  endfunction
endpackage

// File: rtl/fwd_select.sv
// fwd_select: select code for one EX operand mux from the MEM and WB producer slots
module fwd_select
  import fwd_pkg::*;
(
  input  logic      ex_valid,
  input  logic      use_imm,
  input  logic      use_src,
  input  reg_addr_t src,
  input  logic      mem_fwd,
  input  reg_addr_t mem_rd,
  input  logic      wb_fwd,
  input  reg_addr_t wb_rd,
  output logic [1:0] sel
);
  always_comb
    sel = !ex_valid ? FWD_REG :
          use_imm ? FWD_IMM :
          !use_src ? FWD_REG :
          (mem_fwd && mem_rd == src) ? FWD_EXMEM :
          (wb_fwd && wb_rd == src) ? FWD_MEMWB : FWD_REG;
endmodule

// File: rtl/forward_ctrl_unit.sv
// forward_ctrl_unit: load-use stall detection and EX operand forwarding selects.
// Define FWD_PERF_EN to add stall_cnt / fwd_cnt performance counters.
module forward_ctrl_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  id_use_rs2,
  input  logic                  id_use_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           fwd_cnt
`endif
);
  slot_t id, ex, mem, wb;
  logic mem_fwd, wb_fwd, wb_unused;
  always_comb begin
    stall = !flush && id_valid && writes_reg(ex) && ex.is_load &&
            (ex.rd == reg_addr_t'(id_rs1) || (id_use_rs2 && ex.rd == reg_addr_t'(id_rs2)));
    id = '{valid: id_valid && !stall && !flush, rs1: reg_addr_t'(id_rs1), rs2: reg_addr_t'(id_rs2),
           rd: reg_addr_t'(id_rd), reg_write: id_reg_write, is_load: id_is_load,
           use_rs2: id_use_rs2, use_imm: id_use_imm};
    mem_fwd = writes_reg(mem) && !mem.is_load;
    wb_fwd = writes_reg(wb);
  end
  // WB only ever supplies rd; its source fields are carried for completeness
  assign wb_unused = ^{wb.rs1, wb.rs2, wb.is_load, wb.use_rs2, wb.use_imm};
  always_ff @(posedge clk)
    if (reset) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
    end else begin
      ex <= id;
      mem <= ex;
      wb <= mem;
    end
  fwd_select u_sel_a (
    .ex_valid(ex.valid), .use_imm(1'b0), .use_src(1'b1), .src(ex.rs1),
    .mem_fwd(mem_fwd), .mem_rd(mem.rd), .wb_fwd(wb_fwd), .wb_rd(wb.rd), .sel(fwd_a)
  );
  fwd_select u_sel_b (
    .ex_valid(ex.valid), .use_imm(ex.use_imm), .use_src(ex.use_rs2), .src(ex.rs2),
    .mem_fwd(mem_fwd), .mem_rd(mem.rd), .wb_fwd(wb_fwd), .wb_rd(wb.rd), .sel(fwd_b)
  );
`ifdef FWD_PERF_EN
  always_ff @(posedge clk)
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(stall);
      fwd_cnt <= fwd_cnt + 32'(fwd_a inside {FWD_EXMEM, FWD_MEMWB} || fwd_b inside {FWD_EXMEM, FWD_MEMWB});
    end
`endif
endmodule

// File: tb/tb_forward_ctrl_unit.sv
// tb_forward_ctrl_unit: directed and randomized checks against an instruction-level pipeline model
module tb_forward_ctrl_unit;
  typedef struct {bit v, rw, ld, u2, ui; int rs1, rs2, rd;} ins_t;
  logic clk = 1'b0, reset, id_valid, id_reg_write, id_is_load, id_use_rs2, id_use_imm, flush, stall;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_a, fwd_b;
`ifdef FWD_PERF_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif
  int total = 0, bad = 0, m_stalls = 0, m_fwds = 0;
  ins_t nop, cur, m_ex, m_mem, m_wb;
  bit cur_fl;

  forward_ctrl_unit #(.REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_use_rs2(id_use_rs2), .id_use_imm(id_use_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .stall(stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef FWD_PERF_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic ins_t mk(bit rw, bit ld, bit u2, bit ui, int rs1, int rs2, int rd);
    mk = '{1'b1, rw, ld, u2, ui, rs1, rs2, rd};
  endfunction

  function automatic bit exp_stall();
    return !cur_fl && cur.v && m_ex.v && m_ex.ld && m_ex.rw && m_ex.rd != 0 &&
           (m_ex.rd == cur.rs1 || (cur.u2 && m_ex.rd == cur.rs2));
  endfunction

  // youngest forwardable older producer wins: index 0 = EX/MEM (code 01), 1 = MEM/WB (code 10)
  function automatic logic [1:0] exp_fwd(bit is_b);
    ins_t prod[2];
    int src;
    if (!m_ex.v) return 2'b00;
    if (is_b && m_ex.ui) return 2'b11;
    if (is_b && !m_ex.u2) return 2'b00;
    src = is_b ? m_ex.rs2 : m_ex.rs1;
    prod = '{m_mem, m_wb};
    for (int i = 0; i < 2; i++)
      if (prod[i].v && prod[i].rw && prod[i].rd != 0 && prod[i].rd == src && !(i == 0 && prod[i].ld))
        return 2'(i + 1);
    return 2'b00;
  endfunction

  task automatic put(input ins_t i, input bit fl);
    cur = i;
    cur_fl = fl;
    id_valid = i.v;
    id_reg_write = i.rw;
    id_is_load = i.ld;
    id_use_rs2 = i.u2;
    id_use_imm = i.ui;
    id_rs1 = 5'(i.rs1);
    id_rs2 = 5'(i.rs2);
    id_rd = 5'(i.rd);
    flush = fl;
    #1;
  endtask

  task automatic tick();
    bit st;
    logic [1:0] fa, fb;
    st = exp_stall();
    fa = exp_fwd(1'b0);
    fb = exp_fwd(1'b1);
    @(posedge clk);
    if (reset) begin
      m_ex = nop;
      m_mem = nop;
      m_wb = nop;
      m_stalls = 0;
      m_fwds = 0;
    end else begin
      m_stalls += int'(st);
      m_fwds += int'(fa inside {2'b01, 2'b10} || fb inside {2'b01, 2'b10});
      m_wb = m_mem;
      m_mem = m_ex;
      m_ex = cur;
      if (st || cur_fl) m_ex.v = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (3) begin
      put(nop, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    put(nop, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL reset_fwd_a got=%b exp=00", fwd_a); end
    total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL reset_fwd_b got=%b exp=00", fwd_b); end
  endtask

  task automatic test_alu_fwd();
    put(mk(1, 0, 0, 0, 1, 2, 3), 1'b0); tick();
    put(mk(1, 0, 1, 0, 3, 9, 10), 1'b0); tick();
    put(nop, 1'b0);
    total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL alu_fwd_a got=%b exp=01", fwd_a); end
    total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL alu_fwd_b got=%b exp=00", fwd_b); end
    tick(); drain();
  endtask

  task automatic test_wb_fwd();
    put(mk(1, 0, 0, 0, 1, 2, 5), 1'b0); tick();
    put(mk(1, 0, 1, 0, 1, 2, 6), 1'b0); tick();
    put(mk(1, 0, 1, 0, 8, 5, 11), 1'b0); tick();
    put(nop, 1'b0);
    total++; if (fwd_b !== 2'b10) begin bad++; $display("FAIL wb_fwd_b got=%b exp=10", fwd_b); end
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL wb_fwd_a got=%b exp=00", fwd_a); end
    tick(); drain();
  endtask

  task automatic test_load_use();
    ins_t c;
    c = mk(1, 0, 0, 0, 7, 3, 12);
    put(mk(1, 1, 0, 0, 1, 2, 7), 1'b0); tick();
    put(c, 1'b0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_use_stall got=%b exp=1", stall); end
    tick();
    put(c, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_use_release got=%b exp=0", stall); end
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL load_use_bubble got=%b exp=00", fwd_a); end
    tick();
    put(nop, 1'b0);
    total++; if (fwd_a !== 2'b10) begin bad++; $display("FAIL load_use_fwd_a got=%b exp=10", fwd_a); end
    tick(); drain();
  endtask

  task automatic test_mem_priority();
    put(mk(1, 0, 0, 0, 1, 2, 4), 1'b0); tick();
    put(mk(1, 0, 0, 0, 1, 2, 4), 1'b0); tick();
    put(mk(1, 0, 0, 0, 4, 1, 13), 1'b0); tick();
    put(nop, 1'b0);
    total++; if (fwd_a !== 2'b01) begin bad++; $display("FAIL mem_priority got=%b exp=01", fwd_a); end
    tick(); drain();
    put(mk(1, 0, 0, 0, 1, 2, 0), 1'b0); tick();
    put(mk(1, 0, 0, 0, 0, 1, 13), 1'b0); tick();
    put(nop, 1'b0);
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL r0_no_fwd got=%b exp=00", fwd_a); end
    tick(); drain();
  endtask

  task automatic test_flush();
    put(mk(1, 0, 0, 0, 1, 2, 9), 1'b0); tick();
    put(mk(1, 1, 0, 0, 1, 2, 7), 1'b0); tick();
    put(mk(1, 0, 1, 0, 7, 9, 14), 1'b1);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
    tick();
    put(nop, 1'b0);
    total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL flush_bubble_b got=%b exp=00", fwd_b); end
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL flush_bubble_a got=%b exp=00", fwd_a); end
    tick(); drain();
  endtask

  task automatic test_reset_mid_stall();
    ins_t c;
    c = mk(1, 0, 1, 0, 7, 7, 15);
    put(mk(1, 1, 0, 0, 1, 2, 7), 1'b0); tick();
    put(c, 1'b0);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL pre_reset_stall got=%b exp=1", stall); end
    reset = 1'b1; tick(); reset = 1'b0;
    put(c, 1'b0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mid_reset_stall got=%b exp=0", stall); end
    total++; if (fwd_a !== 2'b00) begin bad++; $display("FAIL mid_reset_fwd_a got=%b exp=00", fwd_a); end
    total++; if (fwd_b !== 2'b00) begin bad++; $display("FAIL mid_reset_fwd_b got=%b exp=00", fwd_b); end
    tick(); drain();
  endtask

  task automatic test_imm();
    put(mk(1, 0, 0, 0, 1, 2, 6), 1'b0); tick();
    put(mk(1, 0, 1, 1, 1, 6, 20), 1'b0); tick();
    put(mk(1, 0, 1, 0, 1, 6, 21), 1'b0);
    total++; if (fwd_b !== 2'b11) begin bad++; $display("FAIL imm_fwd_b got=%b exp=11", fwd_b); end
    tick();
    put(nop, 1'b0);
    total++; if (fwd_b !== 2'b10) begin bad++; $display("FAIL imm_next_fwd_b got=%b exp=10", fwd_b); end
    tick(); drain();
  endtask

`ifdef FWD_PERF_EN
  task automatic test_perf();
    reset = 1'b1; put(nop, 1'b0); tick(); reset = 1'b0;
    repeat (3) begin
      put(mk(1, 1, 0, 0, 1, 2, 7), 1'b0); tick();
      put(mk(1, 0, 0, 0, 7, 3, 12), 1'b0); tick(); tick();
    end
    drain();
    put(nop, 1'b0);
    total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL perf_stall_cnt got=%0d exp=3", stall_cnt); end
    total++; if (fwd_cnt !== 32'(m_fwds)) begin bad++; $display("FAIL perf_fwd_cnt got=%0d exp=%0d", fwd_cnt, m_fwds); end
  endtask
`endif

  task automatic test_random();
    ins_t r;
    bit hold;
    r = nop;
    hold = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        r = nop;
        r.v = $urandom_range(0, 7) != 0;
        r.rw = $urandom_range(0, 3) != 0;
        r.ld = $urandom_range(0, 2) == 0;
        r.u2 = $urandom_range(0, 1) == 1;
        r.ui = $urandom_range(0, 3) == 0;
        r.rs1 = $urandom_range(0, 7);
        r.rs2 = $urandom_range(0, 7);
        r.rd = $urandom_range(0, 7);
      end
      reset = $urandom_range(0, 99) == 0;
      put(r, $urandom_range(0, 9) == 0);
      total++; if (stall !== exp_stall()) begin bad++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", n, stall, exp_stall()); end
      total++; if (fwd_a !== exp_fwd(1'b0)) begin bad++; $display("FAIL rand_fwd_a cyc=%0d got=%b exp=%b", n, fwd_a, exp_fwd(1'b0)); end
      total++; if (fwd_b !== exp_fwd(1'b1)) begin bad++; $display("FAIL rand_fwd_b cyc=%0d got=%b exp=%b", n, fwd_b, exp_fwd(1'b1)); end
      hold = exp_stall();
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    nop = '{default: 0};
    m_ex = nop;
    m_mem = nop;
    m_wb = nop;
    reset = 1'b1;
    put(nop, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_alu_fwd();
    test_wb_fwd();
    test_load_use();
    test_mem_priority();
    test_flush();
    test_reset_mid_stall();
    test_imm();
`ifdef FWD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
